// File: rtl/se_pkg.sv
// Shared types and widths for the paired secure-execution driver.
// Holds the FSM state encoding, default datapath width and counter/skew widths.
package se_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int CNT_W      = 16;
    localparam int SKEW_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_REPORT
    } state_t;

    // Absolute difference of two timestamps, clamped to the skew field width.
    function automatic logic [SKEW_W-1:0] satSkew(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] diff;
        diff = (a > b) ? (a - b) : (b - a);
        return (diff > CNT_W'((1 << SKEW_W) - 1)) ? {SKEW_W{1'b1}} : diff[SKEW_W-1:0];
    endfunction

endpackage

// File: rtl/se_arrival_tracker.sv
// Per-copy arrival record: remembers whether the copy's result has come back,
// the cycle-counter value at arrival and the result itself.
module se_arrival_tracker
    import se_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_capture,
    input  logic [DATA_W-1:0] i_result,
    input  logic [CNT_W-1:0]  i_count,
    output logic              o_arrived,
    output logic [CNT_W-1:0]  o_time,
    output logic [DATA_W-1:0] o_result
);

    logic              r_arrived;
    logic [CNT_W-1:0]  r_time;
    logic [DATA_W-1:0] r_result;

    // Only the first arrival of a transaction is recorded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_arrived <= 1'b0;
            r_time    <= '0;
            r_result  <= '0;
        end else if (i_clear) begin
            r_arrived <= 1'b0;
            r_time    <= '0;
            r_result  <= '0;
        end else if (i_capture && !r_arrived) begin
            r_arrived <= 1'b1;
            r_time    <= i_count;
            r_result  <= i_result;
        end
    end

    assign o_arrived = r_arrived;
    assign o_time    = r_time;
    assign o_result  = r_result;

endmodule

// File: rtl/se_pair_driver.sv
// Issues one command to two redundant secure-execution copies and reports
// arrival skew, timeout and result mismatch as a leak verdict.
module se_pair_driver
    import se_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 1000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [7:0]        i_cmd_inst,
    input  logic [DATA_W-1:0] i_cmd_op1,
    input  logic [DATA_W-1:0] i_cmd_op2,
    input  logic [DATA_W-1:0] i_cmd_condA,
    input  logic [DATA_W-1:0] i_cmd_condB,
    output logic [7:0]        o_se_inst,
    output logic [DATA_W-1:0] o_se_op1,
    output logic [DATA_W-1:0] o_se_op2,
    output logic [DATA_W-1:0] o_se_condA,
    output logic [DATA_W-1:0] o_se_condB,
    output logic              o_se_validA,
    input  logic              i_se_readyA,
    output logic              o_se_validB,
    input  logic              i_se_readyB,
    input  logic [DATA_W-1:0] i_se_resultA,
    input  logic [DATA_W-1:0] i_se_resultB,
    input  logic              i_se_out_validA,
    input  logic              i_se_out_validB,
    output logic              o_se_out_readyA,
    output logic              o_se_out_readyB,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [SKEW_W-1:0] o_rsp_skew,
    output logic              o_rsp_leak,
    output logic              o_rsp_timeout,
    output logic              o_rsp_mismatch,
    output logic [DATA_W-1:0] o_rsp_result
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_nextState;
    logic [7:0]        r_inst;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_condA;
    logic [DATA_W-1:0] r_condB;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_accA;
    logic              r_accB;
    logic              r_timeout;

    logic              w_cmdFire;
    logic              w_active;
    logic              w_capA;
    logic              w_capB;
    logic              w_arrA;
    logic              w_arrB;
    logic              w_bothArrived;
    logic              w_timeoutHit;
    logic [CNT_W-1:0]  w_timeA;
    logic [CNT_W-1:0]  w_timeB;
    logic [DATA_W-1:0] w_resA;
    logic [DATA_W-1:0] w_resB;
    logic [SKEW_W-1:0] w_skew;

    assign w_cmdFire     = (r_state == ST_IDLE) && i_cmd_valid;
    assign w_active      = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign w_bothArrived = w_arrA && w_arrB;
    assign w_timeoutHit  = (r_cnt >= TIMEOUT_C) && !w_bothArrived;

    assign o_se_out_readyA = w_active && !w_arrA;
    assign o_se_out_readyB = w_active && !w_arrB;
    assign w_capA          = i_se_out_validA && o_se_out_readyA;
    assign w_capB          = i_se_out_validB && o_se_out_readyB;

    se_arrival_tracker #(.DATA_W(DATA_W)) u_trackA (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_cmdFire),
        .i_capture (w_capA),
        .i_result  (i_se_resultA),
        .i_count   (r_cnt),
        .o_arrived (w_arrA),
        .o_time    (w_timeA),
        .o_result  (w_resA)
    );

    se_arrival_tracker #(.DATA_W(DATA_W)) u_trackB (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_cmdFire),
        .i_capture (w_capB),
        .i_result  (i_se_resultB),
        .i_count   (r_cnt),
        .o_arrived (w_arrB),
        .o_time    (w_timeB),
        .o_result  (w_resB)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Timeout is checked before completion so a result landing on the
    // deadline cycle still yields a timeout verdict.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) w_nextState = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_timeoutHit)          w_nextState = ST_REPORT;
                else if (r_accA && r_accB) w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_timeoutHit)       w_nextState = ST_REPORT;
                else if (w_bothArrived) w_nextState = ST_REPORT;
            end
            ST_REPORT: begin
                if (i_rsp_ready) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inst    <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_condA   <= '0;
            r_condB   <= '0;
            r_cnt     <= '0;
            r_accA    <= 1'b0;
            r_accB    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_cmdFire) begin
            r_inst    <= i_cmd_inst;
            r_op1     <= i_cmd_op1;
            r_op2     <= i_cmd_op2;
            r_condA   <= i_cmd_condA;
            r_condB   <= i_cmd_condB;
            r_cnt     <= '0;
            r_accA    <= 1'b0;
            r_accB    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_active && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + 1'b1;
            if (o_se_validA && i_se_readyA)     r_accA <= 1'b1;
            if (o_se_validB && i_se_readyB)     r_accB <= 1'b1;
            if (w_active && w_timeoutHit)       r_timeout <= 1'b1;
        end
    end

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_se_inst   = r_inst;
    assign o_se_op1    = r_op1;
    assign o_se_op2    = r_op2;
    assign o_se_condA  = r_condA;
    assign o_se_condB  = r_condB;
    assign o_se_validA = (r_state == ST_ISSUE) && !r_accA;
    assign o_se_validB = (r_state == ST_ISSUE) && !r_accB;

    // Verdict fields are only driven while the response is offered.
    assign w_skew         = r_timeout ? '0 : satSkew(w_timeA, w_timeB);
    assign o_rsp_valid    = (r_state == ST_REPORT);
    assign o_rsp_timeout  = o_rsp_valid && r_timeout;
    assign o_rsp_skew     = o_rsp_valid ? w_skew : '0;
    assign o_rsp_leak     = o_rsp_valid && (r_timeout || (w_skew != '0));
    assign o_rsp_mismatch = o_rsp_valid && w_bothArrived && (w_resA != w_resB);
    assign o_rsp_result   = o_rsp_valid ? w_resA : '0;

endmodule

// File: tb/tb_se_pair_driver.sv
// Self-checking bench for se_pair_driver: directed verdict scenarios, a reset
// abort, then randomized transactions scored against an arrival-time model.
module tb_se_pair_driver;

    localparam int DW    = 32;
    localparam int TO    = 20;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rstN;
    logic          cmdValid;
    logic          cmdReady;
    logic [7:0]    cmdInst;
    logic [DW-1:0] cmdOp1, cmdOp2, cmdCondA, cmdCondB;
    logic [7:0]    seInst;
    logic [DW-1:0] seOp1, seOp2, seCondA, seCondB;
    logic          seValidA, seReadyA, seValidB, seReadyB;
    logic [DW-1:0] seResultA, seResultB;
    logic          seOutValidA, seOutValidB, seOutReadyA, seOutReadyB;
    logic          rspValid, rspReady;
    logic [7:0]    rspSkew;
    logic          rspLeak, rspTimeout, rspMismatch;
    logic [DW-1:0] rspResult;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    se_pair_driver #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk           (clk),
        .i_rst_n         (rstN),
        .i_cmd_valid     (cmdValid),
        .o_cmd_ready     (cmdReady),
        .i_cmd_inst      (cmdInst),
        .i_cmd_op1       (cmdOp1),
        .i_cmd_op2       (cmdOp2),
        .i_cmd_condA     (cmdCondA),
        .i_cmd_condB     (cmdCondB),
        .o_se_inst       (seInst),
        .o_se_op1        (seOp1),
        .o_se_op2        (seOp2),
        .o_se_condA      (seCondA),
        .o_se_condB      (seCondB),
        .o_se_validA     (seValidA),
        .i_se_readyA     (seReadyA),
        .o_se_validB     (seValidB),
        .i_se_readyB     (seReadyB),
        .i_se_resultA    (seResultA),
        .i_se_resultB    (seResultB),
        .i_se_out_validA (seOutValidA),
        .i_se_out_validB (seOutValidB),
        .o_se_out_readyA (seOutReadyA),
        .o_se_out_readyB (seOutReadyB),
        .o_rsp_valid     (rspValid),
        .i_rsp_ready     (rspReady),
        .o_rsp_skew      (rspSkew),
        .o_rsp_leak      (rspLeak),
        .o_rsp_timeout   (rspTimeout),
        .o_rsp_mismatch  (rspMismatch),
        .o_rsp_result    (rspResult)
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearSeInputs();
        seReadyA = 1'b0; seReadyB = 1'b0;
        seOutValidA = 1'b0; seOutValidB = 1'b0;
        seResultA = '0; seResultB = '0;
    endtask

    // Copy X is accepted in cycle dX and returns its result in cycle tX
    // (cycles counted from the first ISSUE cycle, i.e. the counter value).
    // NEVER means that copy's result never appears.
    task automatic applyStimulus(input int dA, input int dB, input int tA, input int tB,
                                 input logic [DW-1:0] resA, input logic [DW-1:0] resB,
                                 input int hold);
        int w, tMax, c0, expK, lastK, expSkew, k, repK, cntVA, cntVB, diff;
        bit expTo, gotA, gotB, expLeak, expMis;
        logic [DW-1:0] expRes, op1v;

        w     = ((dA > dB) ? dA : dB) + 2;
        tMax  = (tA > tB) ? tA : tB;
        c0    = (w > tMax + 1) ? w : tMax + 1;
        expTo = (c0 > TO);
        expK  = expTo ? TO + 1 : c0 + 1;
        lastK = expK - 1;
        gotA  = (tA <= lastK);
        gotB  = (tB <= lastK);
        diff  = (tA > tB) ? tA - tB : tB - tA;
        expSkew = expTo ? 0 : ((diff > 255) ? 255 : diff);
        expLeak = expTo || (expSkew != 0);
        expMis  = gotA && gotB && (resA != resB);
        expRes  = gotA ? resA : '0;

        @(negedge clk);
        checkOutput("cmdReadyIdle", cmdReady, 1);
        op1v     = $urandom;
        cmdValid = 1'b1;
        cmdInst  = 8'($urandom);
        cmdOp1   = op1v;
        cmdOp2   = $urandom;
        cmdCondA = $urandom;
        cmdCondB = $urandom;
        @(posedge clk);
        @(negedge clk);
        cmdValid = 1'b0;
        checkOutput("cmdReadyBusy", cmdReady, 0);
        checkOutput("seOp1Latched", seOp1, op1v);

        k = 0; repK = -1; cntVA = 0; cntVB = 0;
        while (k < 200) begin
            if (rspValid) begin
                repK = k;
                break;
            end
            if (seValidA) cntVA++;
            if (seValidB) cntVB++;
            seReadyA    = (k >= dA);
            seReadyB    = (k >= dB);
            seOutValidA = (k == tA);
            seOutValidB = (k == tB);
            seResultA   = resA;
            seResultB   = resB;
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        clearSeInputs();
        checkOutput("reportCycle", repK, expK);
        checkOutput("validACycles", cntVA, dA + 1);
        checkOutput("validBCycles", cntVB, dB + 1);

        for (int h = 0; h <= hold; h++) begin
            checkOutput("rspValid", rspValid, 1);
            checkOutput("rspSkew", rspSkew, expSkew);
            checkOutput("rspTimeout", rspTimeout, expTo);
            checkOutput("rspLeak", rspLeak, expLeak);
            checkOutput("rspMismatch", rspMismatch, expMis);
            checkOutput("rspResult", rspResult, expRes);
            rspReady = (h == hold);
            @(posedge clk);
            @(negedge clk);
        end
        rspReady = 1'b0;
        checkOutput("backToIdle", cmdReady, 1);
        checkOutput("rspDropped", rspValid, 0);
    endtask

    initial begin
        int rvCount;
        rstN = 1'b0; cmdValid = 1'b0; rspReady = 1'b0;
        cmdInst = '0; cmdOp1 = '0; cmdOp2 = '0; cmdCondA = '0; cmdCondB = '0;
        clearSeInputs();
        repeat (3) @(negedge clk);
        checkOutput("resetCmdReady", cmdReady, 1);
        checkOutput("resetRspValid", rspValid, 0);
        checkOutput("resetSeValidA", seValidA, 0);
        checkOutput("resetSeInst", seInst, 0);
        rstN = 1'b1;

        $display("[TB] directed scenarios");
        applyStimulus(0, 0, 4, 4, 32'h5, 32'h5, 0);
        applyStimulus(0, 0, 3, 9, 32'h7, 32'h7, 1);
        applyStimulus(0, 0, 4, NEVER, 32'h9, 32'h9, 1);
        applyStimulus(0, 5, 8, 8, 32'hA, 32'hA, 0);
        applyStimulus(0, 0, 6, 6, 32'h1, 32'h2, 3);
        applyStimulus(2, 0, 0, 20, 32'h3, 32'h3, 0);
        applyStimulus(0, 0, 19, 1, 32'h4, 32'h6, 0);

        $display("[TB] reset during WAIT");
        @(negedge clk);
        cmdValid = 1'b1; cmdOp1 = 32'hDEAD; cmdInst = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        cmdValid = 1'b0;
        seReadyA = 1'b1; seReadyB = 1'b1;
        repeat (4) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("abortCmdReady", cmdReady, 1);
        checkOutput("abortSeOutReadyA", seOutReadyA, 0);
        checkOutput("abortSeOp1", seOp1, 0);
        checkOutput("abortSeInst", seInst, 0);
        checkOutput("abortRspValid", rspValid, 0);
        clearSeInputs();
        @(negedge clk);
        rstN = 1'b1;
        rvCount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rspValid) rvCount++;
        end
        checkOutput("abortNoRsp", rvCount, 0);
        checkOutput("abortIdleReady", cmdReady, 1);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            int dA, dB, tA, tB, hold;
            logic [DW-1:0] resA, resB;
            dA   = $urandom_range(0, 6);
            dB   = $urandom_range(0, 6);
            tA   = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 24));
            tB   = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 24));
            resA = $urandom;
            resB = $urandom_range(0, 1) ? resA : DW'($urandom);
            hold = $urandom_range(0, 3);
            applyStimulus(dA, dB, tA, tB, resA, resB, hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/se_pair_driver.md
SE_PAIR_DRIVER -- requirements
Module: se_pair_driver

Interface
REQ-001 Parameter DATA_W, default 128: operand, condition and result width.
REQ-002 Parameter TIMEOUT, default 1000: maximum cycles in WAIT, counted from entry to ISSUE; range 2..65535.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserted when 0.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-006 cmd_inst  in  8  opcode; cmd_op1, cmd_op2  in  DATA_W  operands.
REQ-007 cmd_condA, cmd_condB  in  DATA_W  secret condition per copy.
REQ-008 se_inst  out  8; se_op1, se_op2  out  DATA_W; both copies share these.
REQ-009 se_condA, se_condB  out  DATA_W  condition per copy.
REQ-010 se_validA/se_readyA, se_validB/se_readyB  out/in  1 each  per-copy input handshake.
REQ-011 se_resultA, se_resultB  in  DATA_W; se_out_validA, se_out_validB  in  1; se_out_readyA, se_out_readyB  out  1.
REQ-012 rsp_valid/rsp_ready  out/in  1/1  verdict handshake.
REQ-013 rsp_skew  out  8  saturated arrival difference, cycles.
REQ-014 rsp_leak, rsp_timeout, rsp_mismatch  out  1 each; rsp_result  out  DATA_W  copy-A result.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, REPORT; reset state IDLE.
REQ-016 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, register all cmd_* fields, clear cycle counter and both arrival flags, go to ISSUE.
REQ-017 ISSUE: se_validA held high until se_validA&se_readyA, se_validB likewise, independently; once a side is accepted its valid drops next cycle and stays low.
REQ-018 ISSUE -> WAIT in the cycle after both sides have been accepted; acceptance of both in the same cycle is legal.
REQ-019 Cycle counter is 16 bits, increments every cycle in ISSUE and WAIT, saturates at 65535.
REQ-020 se_out_readyX=1 in ISSUE and WAIT while side X is not yet captured; a result arriving during ISSUE is captured.
REQ-021 On se_out_validX&se_out_readyX: latch se_resultX, set arrived flag X, record counter value as tX.
REQ-022 Go to REPORT in the cycle after both flags are set, or when counter reaches TIMEOUT with either flag clear (timeout wins if simultaneous).
REQ-023 rsp_skew = min(|tA - tB|, 255); 0 when timeout.
REQ-024 rsp_timeout=1 iff REPORT entered by timeout; rsp_leak = rsp_timeout | (rsp_skew != 0).
REQ-025 rsp_mismatch = both arrived & (resultA != resultB); rsp_result = latched resultA (0 if A not arrived).
REQ-026 REPORT: rsp_valid=1, fields stable; on rsp_ready go to IDLE; cmd_ready=0 in all states except IDLE.
REQ-027 Late SE outputs after timeout are ignored (se_out_ready low outside ISSUE/WAIT).

Reset
REQ-028 Reset asynchronously forces state IDLE and all outputs to 0 except cmd_ready=1.
REQ-029 Reset mid-operation discards the transaction, clears counter, flags and latched data; no rsp_valid is produced for it.

Structure
REQ-030 Shared package se_pkg holds the state enum, DATA_W default, counter width 16 and skew width 8.
REQ-031 One sub-module se_arrival_tracker, instantiated per copy: arrived flag, timestamp and result latch.

Verification
REQ-032 Both copies ready, both results 0x5 at counter 4 -> rsp_skew=0, rsp_leak=0, rsp_mismatch=0, rsp_result=0x5.
REQ-033 A result at counter 3, B at counter 9 -> rsp_skew=6, rsp_leak=1.
REQ-034 B never returns, TIMEOUT=20 -> REPORT at counter 20, rsp_timeout=1, rsp_leak=1, rsp_skew=0.
REQ-035 se_readyB low 5 cycles after se_readyA -> se_validB held 5 extra cycles, se_validA single cycle; transaction completes.
REQ-036 Results 0x1 vs 0x2 same cycle -> rsp_mismatch=1, rsp_leak=0; rsp_ready held low 3 cycles -> fields stable.
REQ-037 reset driven low during WAIT -> outputs cleared immediately, cmd_ready=1 after release, no rsp_valid.
